ezp_pkt_builder: RTL and testbench
==================================

// Module: ezp_pkt_builder
// PURPOSE
//  EZPack packet framer: upstream stage of ezp_uart_tx. Accepts a header (type, length), then a
//  valid/ready byte stream of payload. Builds the flat EZPack vector
//  {END, CHK, PD, LEN, TYPE, START} and holds it on o_data with o_valid until ezp_uart_tx takes it.
//  Output layout is bit-identical to what ezp_uart_rx produces, so RX->TX loopback and
//  locally generated packets share one format.
// PARAMETERS
//  START_BYTE  8'hAA        frame start byte, placed at byte 0
//  END_BYTE    8'h55        frame end byte, placed at byte MAX_PKTLEN-1
//  MAX_PD_LEN  2            maximum payload bytes
//  MAX_PKTLEN  MAX_PD_LEN+5 total packet bytes
// PORTS
//  clk          in   1               system clock, all state on rising edge
//  rst          in   1               asynchronous, active-low reset
//  i_hdr_valid  in   1               header present
//  i_hdr_type   in   8               packet TYPE byte
//  i_hdr_len    in   8               payload length in bytes
//  o_hdr_ready  out  1               header accepted when high with i_hdr_valid
//  i_pd_data    in   8               payload byte
//  i_pd_valid   in   1               payload byte present
//  o_pd_ready   out  1               payload byte accepted when high with i_pd_valid
//  o_data       out  8*MAX_PKTLEN    packet vector; byte k at bits [8k+7:8k]
//  o_valid      out  1               o_data holds a complete packet
//  i_ready      in   1               downstream (ezp_uart_tx) accepts packet
//  o_len_err    out  1               1-cycle pulse: header rejected, len > MAX_PD_LEN
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, o_data=0, o_valid=0, o_len_err=0, byte count=0, sum=0.
//  o_hdr_ready = (state==IDLE); o_pd_ready = (state==COLLECT); o_valid = (state==EMIT).
//  Byte layout, fixed positions:
//   - byte0=START_BYTE, byte1=TYPE, byte2=LEN, bytes 3..3+MAX_PD_LEN-1 = payload (first received
//     byte at byte3).
//   - Unused payload bytes are 8'h00.
//   - byte MAX_PKTLEN-2 = CHK, byte MAX_PKTLEN-1 = END_BYTE.
//  CHK = (TYPE + LEN + sum of the LEN payload bytes) mod 256; 8-bit wrap-around accumulator.
//  FSM:
//   IDLE: on i_hdr_valid (o_hdr_ready is 1):
//    - len > MAX_PD_LEN: o_len_err=1 next cycle only, stay IDLE, o_data unchanged.
//    - len == 0: latch header, CHK=TYPE+LEN, clear payload bytes, go EMIT.
//    - 1 <= len <= MAX_PD_LEN: latch TYPE/LEN, payload bytes cleared, count=0, sum=TYPE+LEN, go COLLECT.
//   COLLECT: each i_pd_valid&o_pd_ready cycle:
//    - store byte at index count, sum += byte, count++.
//    - On the byte with count==LEN-1: write CHK and END, go EMIT.
//    - Latency: o_valid is high the cycle after the last payload byte handshake.
//   EMIT: o_data and o_valid held stable. On o_valid&i_ready, go IDLE the next cycle;
//   o_valid=0 from then on. o_data retains the last packet until the next header is accepted.
//  While in EMIT or COLLECT, headers are not accepted (o_hdr_ready=0), so they cannot be lost or
//  overlap. Payload bytes are not accepted in IDLE/EMIT (o_pd_ready=0).
//  Throughput: one packet per (LEN+2) cycles minimum with i_ready held high.
//  rst asserted mid-COLLECT or mid-EMIT: partial packet discarded, o_valid drops immediately
//  (async); after release the block is in IDLE and accepts a new header.
//  Inputs are sampled only on handshake cycles; values on non-handshake cycles are ignored.
// TESTING
//  1. hdr type=0x01 len=2, payload 0x12,0x34, i_ready=1
//     -> o_valid 1 cycle after 0x34 accepted; o_data=56'h55_49_34_12_02_01_AA.
//  2. hdr type=0x10 len=1, payload 0xFF
//     -> CHK wraps to 0x10; o_data=56'h55_10_00_FF_01_10_AA.
//  3. hdr type=0x20 len=0 -> EMIT next cycle with no payload handshake;
//     o_data=56'h55_20_00_00_00_20_AA.
//  4. hdr len=3 -> o_len_err single pulse, o_valid stays 0, o_hdr_ready stays 1;
//     a valid header next cycle is accepted normally.
//  5. Test 1 with i_ready=0 for 10 cycles, with i_hdr_valid and i_pd_valid asserted throughout
//     -> o_data stable, o_hdr_ready=0, o_pd_ready=0, no extra handshakes;
//     release i_ready -> one transfer, then IDLE.
//  6. rst pulsed low after first payload byte of a len=2 packet -> outputs at reset values;
//     next packet (test 2 stimulus) yields the exact test 2 o_data.

Source files
------------

// File: rtl/ezp_pkt_builder.sv
// EZPack packet framer: collects a header and a byte stream of payload and
// builds the flat {END, CHK, PD, LEN, TYPE, START} vector for ezp_uart_tx.
module ezp_pkt_builder #(
   parameter logic [7:0] START_BYTE = 8'hAA,
   parameter logic [7:0] END_BYTE   = 8'h55,
   parameter int         MAX_PD_LEN = 2,
   parameter int         MAX_PKTLEN = MAX_PD_LEN + 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_hdr_valid,
   input  logic [7:0]                i_hdr_type,
   input  logic [7:0]                i_hdr_len,
   output logic                      o_hdr_ready,
   input  logic [7:0]                i_pd_data,
   input  logic                      i_pd_valid,
   output logic                      o_pd_ready,
   output logic [8*MAX_PKTLEN-1:0]   o_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_len_err
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_PD_LEN);
   localparam int         TYPE_LSB  = 8;
   localparam int         LEN_LSB   = 16;
   localparam int         PD_LSB    = 24;
   localparam int         CHK_LSB   = 8 * (MAX_PKTLEN - 2);
   localparam int         END_LSB   = 8 * (MAX_PKTLEN - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [8*MAX_PKTLEN-1:0]   data_q, data_d;
   logic [7:0]                count_q, count_d;
   logic [7:0]                sum_q, sum_d;
   logic [7:0]                len_q, len_d;
   logic                      len_err_q, len_err_d;

   // NOTE: every variable gets its hold value before the case statement, so
   // no path through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      count_d   = count_q;
      sum_d     = sum_q;
      len_d     = len_q;
      len_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_hdr_valid) begin
               if (i_hdr_len > MAX_LEN_B) begin
                  len_err_d = 1'b1;
               end else begin
                  data_d                   = '0;
                  data_d[7:0]              = START_BYTE;
                  data_d[TYPE_LSB +: 8]    = i_hdr_type;
                  data_d[LEN_LSB +: 8]     = i_hdr_len;
                  len_d                    = i_hdr_len;
                  count_d                  = 8'd0;
                  sum_d                    = i_hdr_type + i_hdr_len;
                  if (i_hdr_len == 8'd0) begin
                     // Empty packet: header alone completes the frame.
                     data_d[CHK_LSB +: 8] = i_hdr_type + i_hdr_len;
                     data_d[END_LSB +: 8] = END_BYTE;
                     state_d              = EMIT;
                  end else begin
                     state_d              = COLLECT;
                  end
               end
            end
         end

         COLLECT: begin
            if (i_pd_valid) begin
               for (int k = 0; k < MAX_PD_LEN; k++) begin
                  if (count_q == 8'(k)) begin
                     data_d[PD_LSB + 8*k +: 8] = i_pd_data;
                  end
               end
               sum_d   = sum_q + i_pd_data;
               count_d = count_q + 8'd1;
               if (count_q == len_q - 8'd1) begin
                  data_d[CHK_LSB +: 8] = sum_q + i_pd_data;
                  data_d[END_LSB +: 8] = END_BYTE;
                  state_d              = EMIT;
               end
            end
         end

         EMIT: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   // The packet vector is a small register set, so it is reset with the rest.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         data_q    <= '0;
         count_q   <= 8'd0;
         sum_q     <= 8'd0;
         len_q     <= 8'd0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         count_q   <= count_d;
         sum_q     <= sum_d;
         len_q     <= len_d;
         len_err_q <= len_err_d;
      end
   end

   assign o_hdr_ready = (state_q == IDLE);
   assign o_pd_ready  = (state_q == COLLECT);
   assign o_valid     = (state_q == EMIT);
   assign o_data      = data_q;
   assign o_len_err   = len_err_q;

endmodule

// File: tb/tb_ezp_pkt_builder.sv
// Directed bench for ezp_pkt_builder: table of packets with hand-computed
// frames, then the length-error, back-pressure and mid-packet reset cases.
module tb_ezp_pkt_builder;

   logic        clk;
   logic        rst;
   logic        i_hdr_valid;
   logic [7:0]  i_hdr_type;
   logic [7:0]  i_hdr_len;
   logic        o_hdr_ready;
   logic [7:0]  i_pd_data;
   logic        i_pd_valid;
   logic        o_pd_ready;
   logic [55:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_len_err;

   int checks = 0;
   int errors = 0;
   int xfer_cnt = 0;

   ezp_pkt_builder dut (
      .clk         (clk),
      .rst         (rst),
      .i_hdr_valid (i_hdr_valid),
      .i_hdr_type  (i_hdr_type),
      .i_hdr_len   (i_hdr_len),
      .o_hdr_ready (o_hdr_ready),
      .i_pd_data   (i_pd_data),
      .i_pd_valid  (i_pd_valid),
      .o_pd_ready  (o_pd_ready),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_len_err   (o_len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (o_valid && i_ready) xfer_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      string       name;
      logic [7:0]  ptype;
      logic [7:0]  plen;
      logic [7:0]  pd0;
      logic [7:0]  pd1;
      logic [55:0] exp_data;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Header, payload and delivery with i_ready high; checks handshakes,
   // one-cycle latency to o_valid, the frame, and a single transfer.
   task automatic run_pkt(input string name, input logic [7:0] t, input logic [7:0] l,
                          input logic [7:0] p0, input logic [7:0] p1, input logic [55:0] exp);
      int start_xfer;
      start_xfer = xfer_cnt;
      @(negedge clk);
      check({name, " hdr_ready"}, 64'(o_hdr_ready), 64'd1);
      i_hdr_valid = 1'b1;
      i_hdr_type  = t;
      i_hdr_len   = l;
      @(negedge clk);
      i_hdr_valid = 1'b0;
      for (int i = 0; i < int'(l); i++) begin
         check({name, " pd_ready"}, 64'(o_pd_ready), 64'd1);
         i_pd_valid = 1'b1;
         i_pd_data  = (i == 0) ? p0 : p1;
         @(negedge clk);
      end
      i_pd_valid = 1'b0;
      check({name, " valid"}, 64'(o_valid), 64'd1);
      check({name, " data"}, 64'(o_data), 64'(exp));
      @(negedge clk);
      check({name, " valid_drop"}, 64'(o_valid), 64'd0);
      check({name, " idle"}, 64'(o_hdr_ready), 64'd1);
      check({name, " data_kept"}, 64'(o_data), 64'(exp));
      check({name, " xfers"}, 64'(xfer_cnt - start_xfer), 64'd1);
   endtask

   initial begin
      vecs[0] = '{"t1_basic",   8'h01, 8'd2, 8'h12, 8'h34, 56'h55_49_34_12_02_01_AA};
      vecs[1] = '{"t2_wrap",    8'h10, 8'd1, 8'hFF, 8'h00, 56'h55_10_00_FF_01_10_AA};
      vecs[2] = '{"t3_empty",   8'h20, 8'd0, 8'h00, 8'h00, 56'h55_20_00_00_00_20_AA};
      vecs[3] = '{"all_ff",     8'hFF, 8'd2, 8'hFF, 8'hFF, 56'h55_FF_FF_FF_02_FF_AA};
      vecs[4] = '{"sum_ff",     8'h80, 8'd1, 8'h7E, 8'h00, 56'h55_FF_00_7E_01_80_AA};

      rst = 1'b0;
      i_hdr_valid = 1'b0;
      i_hdr_type  = 8'h00;
      i_hdr_len   = 8'h00;
      i_pd_data   = 8'h00;
      i_pd_valid  = 1'b0;
      i_ready     = 1'b1;
      #12;
      check("rst data",      64'(o_data),      64'd0);
      check("rst valid",     64'(o_valid),     64'd0);
      check("rst len_err",   64'(o_len_err),   64'd0);
      check("rst hdr_ready", 64'(o_hdr_ready), 64'd1);
      check("rst pd_ready",  64'(o_pd_ready),  64'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         run_pkt(vecs[i].name, vecs[i].ptype, vecs[i].plen, vecs[i].pd0, vecs[i].pd1,
                 vecs[i].exp_data);
      end

      // Oversized length: single error pulse, frame untouched, next header taken.
      @(negedge clk);
      i_hdr_valid = 1'b1;
      i_hdr_type  = 8'h33;
      i_hdr_len   = 8'd3;
      @(negedge clk);
      check("t4 len_err",    64'(o_len_err),   64'd1);
      check("t4 valid",      64'(o_valid),     64'd0);
      check("t4 hdr_ready",  64'(o_hdr_ready), 64'd1);
      check("t4 data_kept",  64'(o_data),      64'(vecs[4].exp_data));
      i_hdr_type = 8'h20;
      i_hdr_len  = 8'd0;
      @(negedge clk);
      i_hdr_valid = 1'b0;
      check("t4 len_err_off", 64'(o_len_err), 64'd0);
      check("t4 next valid",  64'(o_valid),   64'd1);
      check("t4 next data",   64'(o_data),    64'h55_20_00_00_00_20_AA);
      @(negedge clk);
      check("t4 back idle",   64'(o_hdr_ready), 64'd1);

      // Back-pressure: EMIT holds with handshake inputs asserted.
      i_ready = 1'b0;
      i_hdr_valid = 1'b1;
      i_hdr_type  = 8'h01;
      i_hdr_len   = 8'd2;
      @(negedge clk);
      i_pd_valid = 1'b1;
      i_pd_data  = 8'h12;
      @(negedge clk);
      i_pd_data  = 8'h34;
      @(negedge clk);
      begin
         int x0;
         x0 = xfer_cnt;
         i_hdr_type = 8'h77;
         i_hdr_len  = 8'd1;
         i_pd_data  = 8'h99;
         for (int c = 0; c < 10; c++) begin
            check("t5 hold valid",     64'(o_valid),     64'd1);
            check("t5 hold data",      64'(o_data),      64'h55_49_34_12_02_01_AA);
            check("t5 hold hdr_ready", 64'(o_hdr_ready), 64'd0);
            check("t5 hold pd_ready",  64'(o_pd_ready),  64'd0);
            @(negedge clk);
         end
         i_hdr_valid = 1'b0;
         i_pd_valid  = 1'b0;
         i_ready     = 1'b1;
         @(negedge clk);
         check("t5 released valid", 64'(o_valid),     64'd0);
         check("t5 released idle",  64'(o_hdr_ready), 64'd1);
         check("t5 one xfer",       64'(xfer_cnt - x0), 64'd1);
         check("t5 data_kept",      64'(o_data),      64'h55_49_34_12_02_01_AA);
      end

      // Reset mid-COLLECT discards the partial packet.
      i_hdr_valid = 1'b1;
      i_hdr_type  = 8'h01;
      i_hdr_len   = 8'd2;
      @(negedge clk);
      i_hdr_valid = 1'b0;
      i_pd_valid  = 1'b1;
      i_pd_data   = 8'h12;
      @(negedge clk);
      i_pd_valid  = 1'b0;
      check("t6 collecting", 64'(o_pd_ready), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("t6 rst data",      64'(o_data),      64'd0);
      check("t6 rst valid",     64'(o_valid),     64'd0);
      check("t6 rst pd_ready",  64'(o_pd_ready),  64'd0);
      check("t6 rst hdr_ready", 64'(o_hdr_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      run_pkt("t6 after_rst", 8'h10, 8'd1, 8'hFF, 8'h00, 56'h55_10_00_FF_01_10_AA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
